// File: rtl/md_if.sv
// ============================================================================
// Module      : md_if
// Description : EX-stage multiply/divide bus. It carries the op, the operands
//               and the flush from the pipeline, and returns the HI/LO and
//               busy status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_if;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        start;
  logic        busy;
  logic        md_state;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, A, B, req,
    input  start, busy, md_state, hi, lo
  );

  modport slave (
    input  md_op, A, B, req,
    output start, busy, md_state, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ============================================================================
// Module      : md_unit
// Description : Multi-cycle MIPS multiply/divide unit that owns HI/LO. The
//               optional madd/maddu/msub/msubu ops are enabled by defining
//               MD_MADD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input wire logic clk,
  input wire logic reset,
  md_if.slave      bus
);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MTHI  = 4'd5;
  localparam logic [3:0] c_OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] c_OP_MADD  = 4'd7;
  localparam logic [3:0] c_OP_MADDU = 4'd8;
  localparam logic [3:0] c_OP_MSUB  = 4'd9;
  localparam logic [3:0] c_OP_MSUBU = 4'd10;
`endif

  localparam int c_MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W = $clog2(c_MAX_N + 1);
  localparam logic [c_CNT_W-1:0] c_MULT_N = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_N  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_1  = c_CNT_W'(1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_BUSY = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        pend_hi_q, pend_lo_q;
  logic               pend_wr_q;

  logic        w_mult_class, w_div_class;
  logic        w_busy, w_start, w_commit, w_mthi, w_mtlo;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_a_mag, w_b_mag, w_b_mag_safe, w_b_safe;
  logic [31:0] w_q_mag, w_r_mag, w_quo_s, w_rem_s, w_quo_u, w_rem_u;
  logic [31:0] w_res_hi, w_res_lo;

  // Op decode
  always_comb begin
    w_mult_class = 1'b0;
    w_div_class  = 1'b0;
    case (bus.md_op)
      c_OP_MULT, c_OP_MULTU: w_mult_class = 1'b1;
      c_OP_DIV,  c_OP_DIVU:  w_div_class  = 1'b1;
`ifdef MD_MADD_EN
      c_OP_MADD, c_OP_MADDU, c_OP_MSUB, c_OP_MSUBU: w_mult_class = 1'b1;
`endif
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= c_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (w_start) state_d = c_BUSY;
      c_BUSY:  if (cnt_q == c_CNT_1) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  // FSM: outputs and strobes
  always_comb begin
    w_busy   = (state_q == c_BUSY);
    w_start  = (w_mult_class | w_div_class) & ~w_busy & ~bus.req;
    w_commit = w_busy & (cnt_q == c_CNT_1);
    w_mthi   = (bus.md_op == c_OP_MTHI) & ~w_busy & ~bus.req;
    w_mtlo   = (bus.md_op == c_OP_MTLO) & ~w_busy & ~bus.req;
  end

  // Low 64 bits of a product of sign-extended operands equal the signed product
  assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
  assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Signed divide via magnitudes; this also makes 0x80000000 / -1 wrap cleanly
  assign w_a_mag      = bus.A[31] ? -bus.A : bus.A;
  assign w_b_mag      = bus.B[31] ? -bus.B : bus.B;
  assign w_b_mag_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
  assign w_b_safe     = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign w_q_mag      = w_a_mag / w_b_mag_safe;
  assign w_r_mag      = w_a_mag % w_b_mag_safe;
  assign w_quo_s      = (bus.A[31] ^ bus.B[31]) ? -w_q_mag : w_q_mag;
  assign w_rem_s      = bus.A[31] ? -w_r_mag : w_r_mag;
  assign w_quo_u      = bus.A / w_b_safe;
  assign w_rem_u      = bus.A % w_b_safe;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (bus.md_op)
      c_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      c_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      c_OP_DIV:   begin w_res_hi = w_rem_s; w_res_lo = w_quo_s; end
      c_OP_DIVU:  begin w_res_hi = w_rem_u; w_res_lo = w_quo_u; end
`ifdef MD_MADD_EN
      c_OP_MADD:  {w_res_hi, w_res_lo} = {hi_q, lo_q} + w_prod_s;
      c_OP_MADDU: {w_res_hi, w_res_lo} = {hi_q, lo_q} + w_prod_u;
      c_OP_MSUB:  {w_res_hi, w_res_lo} = {hi_q, lo_q} - w_prod_s;
      c_OP_MSUBU: {w_res_hi, w_res_lo} = {hi_q, lo_q} - w_prod_u;
`endif
      default: ;
    endcase
  end

  // Counter and pending result; a divide by zero runs full length but never commits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else if (w_start) begin
      cnt_q     <= w_div_class ? c_DIV_N : c_MULT_N;
      pend_hi_q <= w_res_hi;
      pend_lo_q <= w_res_lo;
      pend_wr_q <= ~(w_div_class & (bus.B == 32'd0));
    end else if (w_busy) begin
      cnt_q     <= cnt_q - c_CNT_1;
    end
  end

  // Commit happens only while busy, mthi/mtlo only while idle: never both
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (w_commit) begin
      if (pend_wr_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else if (w_mthi) begin
      hi_q <= bus.A;
    end else if (w_mtlo) begin
      lo_q <= bus.A;
    end
  end

  assign bus.start    = w_start;
  assign bus.busy     = w_busy;
  assign bus.md_state = w_start | w_busy;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ============================================================================
// Module      : tb_md_unit
// Description : Directed vector bench for md_unit (MD_MADD_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_unit;

  typedef struct {
    logic [3:0]  op;
    logic        req;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_start;
    int          exp_cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  md_if u_if ();

  md_unit #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && u_if.busy && u_if.md_op != 4'd0)
      $error("md_op issued while busy");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cycles;
    int md_low;
    @(negedge clk);
    u_if.md_op = v.op;
    u_if.A     = v.a;
    u_if.B     = v.b;
    u_if.req   = v.req;
    #1;
    chk($sformatf("v%0d start", idx), {31'd0, u_if.start}, {31'd0, v.exp_start});
    chk($sformatf("v%0d md_state", idx), {31'd0, u_if.md_state}, {31'd0, v.exp_start});
    @(negedge clk);
    u_if.md_op = 4'd0;
    u_if.req   = 1'b0;
    cycles = 0;
    md_low = 0;
    while (u_if.busy === 1'b1 && cycles < 50) begin
      cycles++;
      if (u_if.md_state !== 1'b1) md_low++;
      @(negedge clk);
    end
    chk($sformatf("v%0d busy_cycles", idx), cycles, v.exp_cycles);
    chk($sformatf("v%0d md_state_gap", idx), md_low, 0);
    chk($sformatf("v%0d hi", idx), u_if.hi, v.exp_hi);
    chk($sformatf("v%0d lo", idx), u_if.lo, v.exp_lo);
  endtask

  vec_t vecs[$];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset      = 1'b0;
    u_if.md_op = 4'd0;
    u_if.A     = 32'd0;
    u_if.B     = 32'd0;
    u_if.req   = 1'b0;

    //              op     req   A             B             st  cyc hi            lo
    vecs.push_back('{4'd1, 1'b0, 32'hFFFFFFFE, 32'h00000003, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFFA});
    vecs.push_back('{4'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5, 32'hFFFFFFFE, 32'h00000001});
    vecs.push_back('{4'd3, 1'b0, 32'hFFFFFFF9, 32'h00000002, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{4'd4, 1'b0, 32'h00000007, 32'h00000000, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{4'd3, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10, 32'h00000000, 32'h80000000});
    vecs.push_back('{4'd4, 1'b0, 32'h00000064, 32'h00000007, 1'b1, 10, 32'h00000002, 32'h0000000E});
    vecs.push_back('{4'd3, 1'b0, 32'h00000007, 32'hFFFFFFFE, 1'b1, 10, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{4'd5, 1'b1, 32'h12345678, 32'h00000000, 1'b0, 0, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{4'd5, 1'b0, 32'h12345678, 32'h00000000, 1'b0, 0, 32'h12345678, 32'hFFFFFFFD});
    vecs.push_back('{4'd6, 1'b0, 32'hCAFEBABE, 32'h00000000, 1'b0, 0, 32'h12345678, 32'hCAFEBABE});
    vecs.push_back('{4'd1, 1'b1, 32'h00000005, 32'h00000005, 1'b0, 0, 32'h12345678, 32'hCAFEBABE});
    vecs.push_back('{4'd11, 1'b0, 32'h00000005, 32'h00000005, 1'b0, 0, 32'h12345678, 32'hCAFEBABE});
    vecs.push_back('{4'd1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFEB});
    vecs.push_back('{4'd5, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 0, 32'h00000000, 32'hFFFFFFEB});
    vecs.push_back('{4'd6, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF});
`ifdef MD_MADD_EN
    vecs.push_back('{4'd8, 1'b0, 32'h00000001, 32'h00000001, 1'b1, 5, 32'h00000001, 32'h00000000});
    vecs.push_back('{4'd9, 1'b0, 32'h00000002, 32'h00000003, 1'b1, 5, 32'h00000000, 32'hFFFFFFFA});
`else
    vecs.push_back('{4'd8, 1'b0, 32'h00000001, 32'h00000001, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF});
`endif

    // Reset state
    #2;
    chk("rst busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst start", {31'd0, u_if.start}, 32'd0);
    chk("rst hi", u_if.hi, 32'd0);
    chk("rst lo", u_if.lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Async reset in the middle of a divide discards the result
    @(negedge clk);
    u_if.md_op = 4'd3;
    u_if.A     = 32'hFFFFFFF9;
    u_if.B     = 32'h00000002;
    @(negedge clk);
    u_if.md_op = 4'd0;
    repeat (3) @(negedge clk);
    chk("mid busy_before", {31'd0, u_if.busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid busy_async", {31'd0, u_if.busy}, 32'd0);
    chk("mid md_state_async", {31'd0, u_if.md_state}, 32'd0);
    chk("mid hi_async", u_if.hi, 32'd0);
    chk("mid lo_async", u_if.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post busy", {31'd0, u_if.busy}, 32'd0);
    chk("post hi", u_if.hi, 32'd0);
    chk("post lo", u_if.lo, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage of the 5-stage MIPS pipeline with CP0.
- Executes mult/multu/div/divu and mthi/mtlo against the architectural HI/LO registers.
- Drives md_state, which feeds the hazard/stall controller; that controller stalls any HI/LO instruction in D while md_state is high.
- mfhi/mflo read the hi/lo outputs directly from EX.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu is accepted (>=1)
- DIV_CYCLES, 10, cycles busy stays high after a div/divu is accepted (>=1)

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- md_op  input  4  EX-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu (7-10 only with the optional feature), others none
- A  input  32  forwarded rs value from EX
- B  input  32  forwarded rt value from EX
- req  input  1  exception/interrupt flush of the EX instruction this cycle; blocks any md_op
- start  output  1  combinational: md_op is a multi-cycle op (1-4, or 7-10 when enabled), busy=0 and req=0
- busy  output  1  registered: an operation is in flight
- md_state  output  1  start | busy; routed to the stall controller
- hi  output  32  architectural HI
- lo  output  32  architectural LO

Behaviour:
- Reset (async, reset=0): busy=0, counter=0, hi=0, lo=0, pending result=0. Takes effect immediately, including mid-operation; the in-flight result is discarded.
- State machine:
  - IDLE (busy=0) -> BUSY on a clock edge where start=1.
  - BUSY -> IDLE when the counter expires.
- Accept (edge t0, start=1):
  - Operands are sampled at t0 and the result is computed into the pending hi/lo registers.
  - Counter loads N, where N = MULT_CYCLES for mult-class ops and DIV_CYCLES for div-class ops.
  - busy=1 from t0 through edge t0+N.
- Completion:
  - The counter decrements each cycle while busy.
  - On the edge where it goes 1->0 (t0+N), hi/lo take the pending values and busy falls on the same edge.
  - A mfhi in EX during the next cycle sees the new value.
- Arithmetic:
  - mult: signed 32x32 -> 64; hi = [63:32], lo = [31:0].
  - multu: unsigned 32x32 -> 64; hi = [63:32], lo = [31:0].
  - div: signed, quotient truncated toward zero -> lo; remainder (sign of dividend) -> hi.
  - divu: unsigned quotient -> lo, remainder -> hi.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (B=0): the operation still runs DIV_CYCLES with busy asserted, but hi/lo remain unchanged at completion.
- mthi/mtlo: single-cycle. With busy=0 and req=0, hi (resp. lo) <= A at the edge; busy is not asserted and start stays 0.
- req=1: any md_op that cycle is ignored (no accept, no mthi/mtlo write). Once BUSY, req has no effect and the operation completes.
- md_op!=0 while busy=1: ignored. The stall controller prevents this; the bench flags it as an assertion.
- md_state is high on the accept cycle (via start) and for every busy cycle, so a following HI/LO instruction in D is stalled without a bubble gap.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - ops 7-10 are accepted as MULT_CYCLES ops.
  - Result computed at accept: {hi,lo} +/- the 64-bit product, using signed (madd/msub) or unsigned (maddu/msubu) multiply. {hi,lo} are the values at the accept edge; wrap mod 2^64.
- Undefined: ops 7-10 are treated as none (start=0, no state change).

Test Plan:
- Reset then mult A=0xFFFFFFFE(-2) B=3 -> start=1 the accept cycle; busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0 on that same edge.
- multu A=0xFFFFFFFF B=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu A=7 B=0 -> busy 10 cycles, hi/lo unchanged.
- mthi A=0x12345678 with req=1 -> hi unchanged. Next cycle mthi A=0x12345678 with req=0 -> hi=0x12345678, busy stays 0, md_state=0.
- Start div, pull reset low at busy cycle 4 -> busy, hi, lo go 0 immediately (asynchronously); after release, no completion update occurs.
- MD_MADD_EN: hi=0, lo=0xFFFFFFFF, then maddu A=1 B=1 -> after 5 cycles hi=1, lo=0. Without the macro, same op -> start=0, hi/lo unchanged.
